// File: rtl/conv_pixel_engine.sv
// One output pixel of a conv layer: MAC over MACS operands per channel, add bias, activate, requantize to int8.
// Define CONV_PIXEL_LEAKY_EN to use leaky-ReLU (x>>>3 for negatives) instead of the linear activation.
module conv_pixel_engine #(
    parameter int MACS    = 288,
    parameter int NUM_CH  = 4,
    parameter int SCALE_Q = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] scale,
    output logic        busy,
    output logic        rd_en,
    output logic [8:0]  rd_addr,
    output logic [7:0]  rd_ch,
    input  logic [7:0]  w_data,
    input  logic [7:0]  a_data,
    output logic        bias_rd_en,
    input  logic [31:0] bias_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_int8,
    output logic [7:0]  out_ch,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ACT,
        QUANT,
        EMIT,
        FIN
    } state_t;

    localparam logic [8:0]         LAST_ADDR = 9'(MACS - 1);
    localparam logic [7:0]         LAST_CH   = 8'(NUM_CH - 1);
    localparam logic signed [63:0] ROUND     = 64'sd1 <<< (SCALE_Q - 1);

    state_t      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [7:0]  ch_q, ch_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] bias_q, bias_d;
    logic [31:0] act_q, act_d;
    logic [15:0] scale_q, scale_d;
    logic [7:0]  out_int8_q, out_int8_d;
    logic        prod_valid_q, prod_valid_d;
    logic        bias_valid_q, bias_valid_d;

    logic signed [15:0] w_ext, a_ext, product;
    logic [31:0]        pre_act;
    logic [31:0]        act_fn;
    logic signed [63:0] act_wide, scale_wide, q_wide;
    logic [7:0]         q_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            ch_q         <= '0;
            acc_q        <= '0;
            bias_q       <= '0;
            act_q        <= '0;
            scale_q      <= '0;
            out_int8_q   <= '0;
            prod_valid_q <= 1'b0;
            bias_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ch_q         <= ch_d;
            acc_q        <= acc_d;
            bias_q       <= bias_d;
            act_q        <= act_d;
            scale_q      <= scale_d;
            out_int8_q   <= out_int8_d;
            prod_valid_q <= prod_valid_d;
            bias_valid_q <= bias_valid_d;
        end
    end

    // Datapath helpers: operand product, activation and requantize with saturation.
    always_comb begin
        w_ext   = {{8{w_data[7]}}, w_data};
        a_ext   = {{8{a_data[7]}}, a_data};
        product = w_ext * a_ext;
        pre_act = acc_q + bias_q;
`ifdef CONV_PIXEL_LEAKY_EN
        act_fn = pre_act[31] ? {{3{pre_act[31]}}, pre_act[31:3]} : pre_act;
`else
        act_fn = pre_act;
`endif
        act_wide   = {{32{act_q[31]}}, act_q};
        scale_wide = {48'd0, scale_q};
        q_wide     = (act_wide * scale_wide + ROUND) >>> SCALE_Q;
        if (q_wide > 64'sd127) begin
            q_sat = 8'h7f;
        end else if (q_wide < -64'sd128) begin
            q_sat = 8'h80;
        end else begin
            q_sat = q_wide[7:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ch_d       = ch_q;
        acc_d      = acc_q;
        bias_d     = bias_q;
        act_d      = act_q;
        scale_d    = scale_q;
        out_int8_d = out_int8_q;

        rd_en      = (state_q == ISSUE);
        bias_rd_en = (state_q == ISSUE) && (addr_q == 9'd0);
        busy       = (state_q != IDLE) && (state_q != FIN);
        out_valid  = (state_q == EMIT);
        done       = (state_q == FIN);

        prod_valid_d = rd_en;
        bias_valid_d = bias_rd_en;

        // Memory data trails each request by one cycle, so the delayed strobes gate capture.
        if (prod_valid_q) begin
            acc_d = acc_q + {{16{product[15]}}, product};
        end
        if (bias_valid_q) begin
            bias_d = bias_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    scale_d = scale;
                    ch_d    = 8'd0;
                    addr_d  = 9'd0;
                    acc_d   = 32'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = 9'd0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 9'd1;
                end
            end
            DRAIN: begin
                state_d = ACT;
            end
            ACT: begin
                act_d   = act_fn;
                state_d = QUANT;
            end
            QUANT: begin
                out_int8_d = q_sat;
                state_d    = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (ch_q == LAST_CH) begin
                        state_d = FIN;
                    end else begin
                        ch_d    = ch_q + 8'd1;
                        acc_d   = 32'd0;
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_addr  = addr_q;
    assign rd_ch    = ch_q;
    assign out_ch   = ch_q;
    assign out_int8 = out_int8_q;

endmodule

// File: tb/tb_conv_pixel_engine.sv
// Scoreboard bench for conv_pixel_engine: a high-level model predicts each channel's int8 result,
// a monitor pops and compares on every handshake and checks read bursts, latency, stalls and done.
module tb_conv_pixel_engine;

    localparam int MACS    = 288;
    localparam int NUM_CH  = 4;
    localparam int SCALE_Q = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] scale;
    logic        busy;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_ch;
    logic [7:0]  w_data;
    logic [7:0]  a_data;
    logic        bias_rd_en;
    logic [31:0] bias_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_int8;
    logic [7:0]  out_ch;
    logic        done;

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_expected = 0;
    int out_count = 0;
    int ready_mode = 0;
    bit stall_done = 1'b0;
    int stall_cycles = 0;

    logic signed [7:0]  w_mem [NUM_CH][MACS];
    logic signed [7:0]  a_mem [MACS];
    logic signed [31:0] bias_mem [NUM_CH];

    conv_pixel_engine #(
        .MACS   (MACS),
        .NUM_CH (NUM_CH),
        .SCALE_Q(SCALE_Q)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .scale     (scale),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_ch     (rd_ch),
        .w_data    (w_data),
        .a_data    (a_data),
        .bias_rd_en(bias_rd_en),
        .bias_data (bias_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int8  (out_int8),
        .out_ch    (out_ch),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memories with one-cycle latency; idle cycles return junk so mistimed captures show up.
    always @(posedge clk) begin
        if (rd_en && int'(rd_ch) < NUM_CH && int'(rd_addr) < MACS) begin
            w_data <= w_mem[int'(rd_ch)][int'(rd_addr)];
            a_data <= a_mem[int'(rd_addr)];
        end else begin
            w_data <= 8'($urandom);
            a_data <= 8'($urandom);
        end
        if (bias_rd_en && int'(rd_ch) < NUM_CH) begin
            bias_data <= bias_mem[int'(rd_ch)];
        end else begin
            bias_data <= $urandom;
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: dot product, 32-bit wrapping bias add, activation, rounded floor-divide, clamp.
    function automatic int model_out(input int c, input int sv);
        longint sum = 0;
        longint x;
        longint n;
        longint d;
        longint q;
        for (int i = 0; i < MACS; i++) begin
            sum += longint'(w_mem[c][i]) * longint'(a_mem[i]);
        end
        x = longint'(int'(sum + longint'(bias_mem[c])));
`ifdef CONV_PIXEL_LEAKY_EN
        if (x < 0) x = (x - 7) / 8;
`endif
        d = longint'(1) << SCALE_Q;
        n = x * longint'(sv) + d / 2;
        q = (n >= 0) ? n / d : (n - (d - 1)) / d;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic fill_job(input int kind, input int wv, input int av, input int bv);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < MACS; i++) begin
                w_mem[c][i] = (kind == 0) ? 8'(wv) : 8'($urandom);
            end
            if (kind == 0) bias_mem[c] = bv;
            else if (kind == 1) bias_mem[c] = int'($urandom_range(0, 2000000)) - 1000000;
            else bias_mem[c] = $urandom;
        end
        for (int i = 0; i < MACS; i++) begin
            a_mem[i] = (kind == 0) ? 8'(av) : 8'($urandom);
        end
    endtask

    task automatic push_expected(input int sv);
        exp_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            e.ch  = 8'(c);
            e.val = 8'(model_out(c, sv));
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int sv);
        start = 1'b1;
        scale = 16'(sv);
        @(posedge clk); #1;
        start = 1'b0;
        scale = 16'($urandom);
    endtask

    task automatic applyStimulus(input int kind, input int wv, input int av, input int bv,
                                 input int sv, input bit poke);
        int budget;
        int out_before;
        fill_job(kind, wv, av, bv);
        push_expected(sv);
        done_expected++;
        out_before = out_count;
        pulse_start(sv);
        if (poke) begin
            repeat (40) @(posedge clk);
            #1;
            pulse_start(int'($urandom_range(0, 65535)));
        end
        budget = 0;
        while (done_seen < done_expected && budget < 5000) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("job_done", done_seen, done_expected);
        repeat (400) @(posedge clk);
        #1;
        checkOutput("outputs_left", exp_q.size(), 0);
        checkOutput("outputs_per_job", out_count - out_before, NUM_CH);
        checkOutput("done_total", done_seen, done_expected);
        checkOutput("busy_idle", busy, 0);
    endtask

    task automatic applyAbort();
        int budget;
        bit found;
        int out_before;
        fill_job(1, 0, 0, 0);
        push_expected(400);
        out_before = out_count;
        pulse_start(400);
        found = 1'b0;
        budget = 0;
        while (!found && budget < 3000) begin
            @(posedge clk); #1;
            if (rd_en && rd_ch == 8'd2 && rd_addr == 9'd100) found = 1'b1;
            budget++;
        end
        checkOutput("abort_reached", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_rd_en", rd_en, 0);
        repeat (400) @(posedge clk);
        #1;
        checkOutput("abort_outputs", out_count - out_before, 2);
        checkOutput("abort_no_done", done_seen, done_expected);
    endtask

    // Downstream ready: always high, random, or one 20-cycle stall on channel 1.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (!stall_done && out_valid && out_ch == 8'd1) begin
                        out_ready = 1'b0;
                        repeat (20) begin
                            @(posedge clk); #1;
                        end
                        stall_done = 1'b1;
                    end
                    out_ready = 1'b1;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: read-burst shape, output latency, stall stability, scoreboard pops, done pulses.
    initial begin
        bit prev_rd_en = 1'b0;
        bit prev_valid = 1'b0;
        bit held = 1'b0;
        bit addr_ok = 1'b1;
        logic [7:0] held_val = '0;
        logic [7:0] held_ch = '0;
        logic [7:0] burst_ch = '0;
        int burst_len = 0;
        int bias_cnt = 0;
        int issue_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd_en = 1'b0;
                prev_valid = 1'b0;
                held = 1'b0;
                continue;
            end
            if (rd_en && !prev_rd_en) begin
                burst_len = 0;
                bias_cnt = 0;
                addr_ok = 1'b1;
                burst_ch = rd_ch;
                issue_cyc = cyc;
                checkOutput("bias_first", bias_rd_en, 1);
            end
            if (rd_en) begin
                if (int'(rd_addr) != burst_len || rd_ch != burst_ch) addr_ok = 1'b0;
                burst_len++;
            end
            if (bias_rd_en) bias_cnt++;
            if (!rd_en && prev_rd_en) begin
                checkOutput("burst_len", burst_len, MACS);
                checkOutput("bias_reads", bias_cnt, 1);
                checkOutput("addr_seq", addr_ok, 1);
                if (exp_q.size() > 0) checkOutput("burst_ch", burst_ch, exp_q[0].ch);
            end
            if (out_valid && !prev_valid) begin
                checkOutput("latency", cyc - issue_cyc, MACS + 3);
            end
            if (held) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_int8, held_val);
                checkOutput("hold_ch", out_ch, held_ch);
            end
            if (out_valid && !out_ready) begin
                held = 1'b1;
                held_val = out_int8;
                held_ch = out_ch;
                stall_cycles++;
                checkOutput("stall_no_read", rd_en, 0);
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_ch", out_ch, e.ch);
                    checkOutput("out_int8", longint'($signed(out_int8)), longint'($signed(e.val)));
                end
            end
            if (done) begin
                done_seen++;
                checkOutput("busy_at_done", busy, 0);
            end
            prev_rd_en = rd_en;
            prev_valid = out_valid;
        end
    end

    initial begin
        #10ms;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sv;
        rst = 1'b1;
        start = 1'b0;
        scale = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rd_en", rd_en, 0);
        checkOutput("rst_bias_rd_en", bias_rd_en, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_addr", rd_addr, 0);
        checkOutput("rst_rd_ch", rd_ch, 0);
        checkOutput("rst_out_int8", out_int8, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        ready_mode = 0;
        applyStimulus(0, 1, 1, 0, 32768, 1'b0);
        applyStimulus(0, 1, 1, -1000, 32768, 1'b0);
        applyStimulus(0, 2, -3, 0, 655, 1'b0);

        ready_mode = 2;
        stall_done = 1'b0;
        stall_cycles = 0;
        applyStimulus(1, 0, 0, 0, 700, 1'b0);
        checkOutput("stall_cycles", stall_cycles, 20);
        ready_mode = 0;

        applyAbort();
        applyStimulus(1, 0, 0, 0, 300, 1'b0);

        applyStimulus(1, 0, 0, 0, 500, 1'b1);

        ready_mode = 1;
        for (int j = 0; j < 4; j++) begin
            sv = int'($urandom_range(1, 65535) >> $urandom_range(0, 15));
            applyStimulus((j % 2) + 1, 0, 0, 0, sv, 1'b0);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
